light_pattern_driver: RTL and testbench
=======================================

# light_pattern_driver

Downstream of `master_fsm`, drives the bike light LED. Consumes the one-hot mode `state` and the four single-cycle shift pulses (`f1_shift_left/right`, `f2_shift_left/right`), and holds a blink rate register per blink mode. Produces the LED drive for each mode: steady off, steady on, square blink (BLINK1) or double-flash (BLINK2).

## Interface
- `BASE_DIV`, default 50000: clocks per base tick, ≥2.
- `RATE_BITS`, default 8: width of each one-hot rate register, ≥4.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `state`  in  4  one-hot mode: 0001 OFF, 0010 ON, 0100 BLINK1, 1000 BLINK2.
- `f1_shift_left`  in  1  BLINK1 slower pulse.
- `f1_shift_right`  in  1  BLINK1 faster pulse.
- `f2_shift_left`  in  1  BLINK2 slower pulse.
- `f2_shift_right`  in  1  BLINK2 faster pulse.
- `light`  out  1  LED drive, 1 = lit.
- `f1_rate`  out  RATE_BITS  BLINK1 one-hot rate register.
- `f2_rate`  out  RATE_BITS  BLINK2 one-hot rate register.

## Operation
- **Rate registers**
  - One-hot; bit k set means half-period = 2^k base ticks.
  - Reset value: bit 3 set (`8'b0000_1000` for RATE_BITS=8).
  - `shift_left` moves the bit up (slower) and saturates at the MSB. `shift_right` moves it down (faster) and saturates at the LSB.
  - Both pulses high in the same cycle: no change.
  - Shifts are accepted in every mode, not only the matching blink mode.
- **Mode register**
  - `state_q` samples `state` every cycle. Reset value 0001.
  - A non-one-hot `state` (0000, or multiple bits set) is treated as OFF.
- **Mode change** (`state != state_q`): in that cycle, clear the prescaler, `half_cnt` and `slot`, and set `phase` to 1.
- **Prescaler**
  - Counts 0..BASE_DIV-1 and wraps.
  - `base_tick` is high for one clock when the count is BASE_DIV-1.
- **BLINK1**
  - On `base_tick`: if `half_cnt >= half-period(f1_rate) - 1`, toggle `phase` and clear `half_cnt`; else increment `half_cnt`.
  - `light` = `phase`.
- **BLINK2**
  - 8-slot pattern 1,0,1,0,0,0,0,0; each slot lasts half-period(f2_rate) base ticks.
  - `slot` is 3 bits and wraps 7→0.
  - `light` = pattern[`slot`].
- **OFF / ON**: `light` = 0 / 1. Counters are held at 0.
- **Rate change mid-period**
  - Takes effect immediately.
  - The `>=` compare ensures a counter already past the new limit toggles (or advances slot) on the next `base_tick`. No lock-up.
- `light` is decoded only from registers (`state_q`, `phase`, `slot`). There is no combinational path from inputs to `light`.

## Timing
- **Reset values**: `light`=0, `f1_rate`=`f2_rate`=bit 3, `state_q`=0001, all counters 0, `phase`=1.
- **Reset mid-blink** returns every register to its reset value asynchronously.
- **Mode latency**: `state` changes before edge N → `light` reflects the new mode after edge N (1 cycle).
- **Shift latency**: pulse high at edge N → `f*_rate` updated after edge N.
- **BLINK1**
  - Entry lit.
  - First toggle BASE_DIV·2^k clocks after the entry edge.
  - Steady square wave with half-period BASE_DIV·2^k clocks.
- **BLINK2**: each slot lasts BASE_DIV·2^k clocks; full pattern is 8× that.
- **Counter width**: `half_cnt` is RATE_BITS bits, which holds 2^(RATE_BITS-1) - 1 without overflow.

## Structure
- **Shared package `bike_light_pkg`**:
  - mode encodings `MODE_OFF`, `MODE_ON`, `MODE_BLINK1`, `MODE_BLINK2`;
  - `RATE_RESET_IDX` = 3;
  - the BLINK2 pattern constant `8'b0000_0101` (bit i = slot i).
- **Sub-module `rate_shifter`**:
  - parameter RATE_BITS;
  - ports `clk`, `reset`, `shift_left`, `shift_right`, `rate`;
  - saturating one-hot shift register;
  - instantiated twice (f1, f2).
- The top level holds the prescaler, mode register, BLINK1/BLINK2 counters and the output decode.

## Test plan
All scenarios use BASE_DIV=4, RATE_BITS=8.
- **ON/OFF**: `state`=0010 at edge N → `light`=1 after N; `state`=0001 → `light`=0 after the next edge; invalid 0110 → `light`=0.
- **BLINK1 default rate**: enter BLINK1 → `light` high 32 clocks, low 32 clocks, repeating over at least 3 periods.
- **Saturation**:
  - 5 `f1_shift_right` pulses → `f1_rate`=0000_0001, half-period 4 clocks;
  - then 10 `f1_shift_left` pulses → 1000_0000;
  - `f2_rate` unchanged throughout.
- **Simultaneous shifts**: `f2_shift_left` and `f2_shift_right` high together → `f2_rate` stays 0000_1000.
- **BLINK2 and mode switch**:
  - enter BLINK2 → `light` pattern 1,0,1,0,0,0,0,0 with 32 clocks per slot;
  - switch to BLINK1 mid-slot → `light`=1 next cycle, first toggle 32 clocks later.
- **Reset mid-blink**: assert `reset` asynchronously during a BLINK1 low phase after shifts → immediately `light`=0 and both rates 0000_1000.

Source files
------------

// File: rtl/bike_light_pkg.sv
// Shared definitions for the bike light datapath:
// mode encodings, rate reset index and the BLINK2 flash pattern.
package bike_light_pkg;

    typedef enum logic [3:0] {
        MODE_OFF    = 4'b0001,
        MODE_ON     = 4'b0010,
        MODE_BLINK1 = 4'b0100,
        MODE_BLINK2 = 4'b1000
    } mode_t;

    localparam int RATE_RESET_IDX = 3;

    // bit i lights slot i
    localparam logic [7:0] BLINK2_PATTERN = 8'b0000_0101;

    function automatic mode_t mode_decode(input logic [3:0] s);
        case (s)
            4'b0010: return MODE_ON;
            4'b0100: return MODE_BLINK1;
            4'b1000: return MODE_BLINK2;
            default: return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/light_pattern_driver_rate_shifter.sv
// Saturating one-hot rate register; bit k means a
// half-period of 2^k base ticks.
module rate_shifter
    import bike_light_pkg::*;
#(
    parameter int RATE_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 shift_left,
    input  logic                 shift_right,
    output logic [RATE_BITS-1:0] rate
);

    localparam logic [RATE_BITS-1:0] RATE_RST =
        RATE_BITS'(1) << RATE_RESET_IDX;

    logic [RATE_BITS-1:0] rate_d;

    always_comb begin
        rate_d = rate;
        if (shift_left && !shift_right) begin
            if (!rate[RATE_BITS-1])
                rate_d = rate << 1;
        end else if (shift_right && !shift_left) begin
            if (!rate[0])
                rate_d = rate >> 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rate <= RATE_RST;
        else
            rate <= rate_d;
    end

endmodule

// File: rtl/light_pattern_driver.sv
// Bike light LED driver: mode register, base-tick prescaler,
// BLINK1 square wave and BLINK2 double-flash sequencer.
module light_pattern_driver
    import bike_light_pkg::*;
#(
    parameter int BASE_DIV  = 50000,
    parameter int RATE_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           state,
    input  logic                 f1_shift_left,
    input  logic                 f1_shift_right,
    input  logic                 f2_shift_left,
    input  logic                 f2_shift_right,
    output logic                 light,
    output logic [RATE_BITS-1:0] f1_rate,
    output logic [RATE_BITS-1:0] f2_rate
);

    localparam int PW = (BASE_DIV > 2) ? $clog2(BASE_DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(BASE_DIV - 1);
    localparam logic [PW-1:0] DIV_ONE  = PW'(1);
    localparam logic [RATE_BITS-1:0] RATE_ONE = RATE_BITS'(1);

    logic [3:0]           state_q;
    logic [PW-1:0]        presc_q, presc_d;
    logic [RATE_BITS-1:0] half_q, half_d;
    logic [2:0]           slot_q, slot_d;
    logic                 phase_q, phase_d;

    mode_t                mode_q;
    logic                 mode_chg;
    logic                 base_tick;
    logic [RATE_BITS-1:0] lim1, lim2;

    rate_shifter #(.RATE_BITS(RATE_BITS)) u_f1 (
        .clk         (clk),
        .reset       (reset),
        .shift_left  (f1_shift_left),
        .shift_right (f1_shift_right),
        .rate        (f1_rate)
    );

    rate_shifter #(.RATE_BITS(RATE_BITS)) u_f2 (
        .clk         (clk),
        .reset       (reset),
        .shift_left  (f2_shift_left),
        .shift_right (f2_shift_right),
        .rate        (f2_rate)
    );

    assign mode_q    = mode_decode(state_q);
    assign mode_chg  = (state != state_q);
    assign base_tick = (presc_q == DIV_LAST);
    // one-hot rate value equals the half-period in ticks
    assign lim1      = f1_rate - RATE_ONE;
    assign lim2      = f2_rate - RATE_ONE;

    always_comb begin
        presc_d = presc_q;
        half_d  = half_q;
        slot_d  = slot_q;
        phase_d = phase_q;
        if (mode_chg) begin
            presc_d = '0;
            half_d  = '0;
            slot_d  = '0;
            phase_d = 1'b1;
        end else begin
            case (mode_q)
                MODE_BLINK1: begin
                    presc_d = base_tick ? '0 : presc_q + DIV_ONE;
                    if (base_tick) begin
                        if (half_q >= lim1) begin
                            half_d  = '0;
                            phase_d = ~phase_q;
                        end else begin
                            half_d = half_q + RATE_ONE;
                        end
                    end
                end
                MODE_BLINK2: begin
                    presc_d = base_tick ? '0 : presc_q + DIV_ONE;
                    if (base_tick) begin
                        if (half_q >= lim2) begin
                            half_d = '0;
                            slot_d = slot_q + 3'd1;
                        end else begin
                            half_d = half_q + RATE_ONE;
                        end
                    end
                end
                default: begin
                    presc_d = '0;
                    half_d  = '0;
                    slot_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MODE_OFF;
            presc_q <= '0;
            half_q  <= '0;
            slot_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            state_q <= state;
            presc_q <= presc_d;
            half_q  <= half_d;
            slot_q  <= slot_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        light = 1'b0;
        case (mode_q)
            MODE_ON:     light = 1'b1;
            MODE_BLINK1: light = phase_q;
            MODE_BLINK2: light = BLINK2_PATTERN[slot_q];
            default:     light = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_light_pattern_driver.sv
// Directed bench for light_pattern_driver with BASE_DIV=4,
// RATE_BITS=8: vector table plus multi-cycle blink sequences.
module tb_light_pattern_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] state;
    logic       f1l, f1r, f2l, f2r;
    logic       light;
    logic [7:0] f1_rate, f2_rate;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] st;
        logic       f1l, f1r, f2l, f2r;
        logic       e_light;
        logic [7:0] e_f1, e_f2;
    } vec_t;

    vec_t vecs[11];

    light_pattern_driver #(.BASE_DIV(4), .RATE_BITS(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .state          (state),
        .f1_shift_left  (f1l),
        .f1_shift_right (f1r),
        .f2_shift_left  (f2l),
        .f2_shift_right (f2r),
        .light          (light),
        .f1_rate        (f1_rate),
        .f2_rate        (f2_rate)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic a, input logic b,
                         input logic c, input logic d);
        f1l = a; f1r = b; f2l = c; f2r = d;
        step();
        f1l = 0; f1r = 0; f2l = 0; f2r = 0;
    endtask

    task automatic blink1_seq(input string name, input int halfp,
                              input int n);
        logic e;
        state = 4'b0100;
        for (int j = 0; j < n; j++) begin
            step();
            e = ((j / halfp) % 2) == 0;
            check(name, {7'd0, light}, {7'd0, e});
        end
    endtask

    task automatic blink2_seq(input string name, input int slotlen,
                              input int n);
        logic [7:0] pat;
        pat   = 8'b0000_0101;
        state = 4'b1000;
        for (int j = 0; j < n; j++) begin
            step();
            check(name, {7'd0, light},
                  {7'd0, pat[(j / slotlen) % 8]});
        end
    endtask

    initial begin
        vecs[0]  = '{4'b0001, 0, 0, 0, 0, 1'b0, 8'h08, 8'h08};
        vecs[1]  = '{4'b0010, 0, 0, 0, 0, 1'b1, 8'h08, 8'h08};
        vecs[2]  = '{4'b0001, 0, 0, 0, 0, 1'b0, 8'h08, 8'h08};
        vecs[3]  = '{4'b0110, 0, 0, 0, 0, 1'b0, 8'h08, 8'h08};
        vecs[4]  = '{4'b0000, 0, 0, 0, 0, 1'b0, 8'h08, 8'h08};
        vecs[5]  = '{4'b1111, 0, 0, 0, 0, 1'b0, 8'h08, 8'h08};
        vecs[6]  = '{4'b0010, 0, 0, 1, 1, 1'b1, 8'h08, 8'h08};
        vecs[7]  = '{4'b0010, 0, 1, 0, 0, 1'b1, 8'h04, 8'h08};
        vecs[8]  = '{4'b0001, 1, 0, 0, 0, 1'b0, 8'h08, 8'h08};
        vecs[9]  = '{4'b0001, 0, 0, 1, 0, 1'b0, 8'h08, 8'h10};
        vecs[10] = '{4'b0001, 0, 0, 0, 1, 1'b0, 8'h08, 8'h08};

        reset = 1'b1;
        state = 4'b0001;
        f1l = 0; f1r = 0; f2l = 0; f2r = 0;
        #12;
        check("rst_light", {7'd0, light}, 8'h00);
        check("rst_f1", f1_rate, 8'h08);
        check("rst_f2", f2_rate, 8'h08);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            state = vecs[i].st;
            f1l = vecs[i].f1l; f1r = vecs[i].f1r;
            f2l = vecs[i].f2l; f2r = vecs[i].f2r;
            step();
            check($sformatf("vec%0d_light", i),
                  {7'd0, light}, {7'd0, vecs[i].e_light});
            check($sformatf("vec%0d_f1", i), f1_rate, vecs[i].e_f1);
            check($sformatf("vec%0d_f2", i), f2_rate, vecs[i].e_f2);
        end
        f1l = 0; f1r = 0; f2l = 0; f2r = 0;

        blink1_seq("b1_default", 32, 192);

        state = 4'b0001;
        step();
        blink2_seq("b2_pattern", 32, 330);
        blink1_seq("b2_to_b1", 32, 65);

        state = 4'b0001;
        step();
        for (int i = 0; i < 5; i++) pulse(0, 1, 0, 0);
        check("sat_right_f1", f1_rate, 8'h01);
        check("sat_right_f2", f2_rate, 8'h08);
        blink1_seq("b1_fast", 4, 24);
        state = 4'b0001;
        step();
        for (int i = 0; i < 10; i++) pulse(1, 0, 0, 0);
        check("sat_left_f1", f1_rate, 8'h80);
        check("sat_left_f2", f2_rate, 8'h08);

        for (int i = 0; i < 7; i++) pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        check("pre_rst_f1", f1_rate, 8'h01);
        check("pre_rst_f2", f2_rate, 8'h10);
        blink1_seq("b1_pre_rst", 4, 7);
        check("low_phase", {7'd0, light}, 8'h00);
        step();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_light", {7'd0, light}, 8'h00);
        check("async_rst_f1", f1_rate, 8'h08);
        check("async_rst_f2", f2_rate, 8'h08);
        state = 4'b0001;
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_rst_light", {7'd0, light}, 8'h00);
        blink1_seq("b1_post_rst", 32, 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
